// File: rtl/cordic_sincos_preproc_if.sv
// Angle handshake and seeded output bundle between the CORDIC input stage
// and its neighbours.
interface cordic_sincos_preproc_if #(
  parameter int BITS = 16
);
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_theta;
  logic            o_valid;
  logic            o_sign;
  logic [BITS-1:0] o_cos;
  logic [BITS-1:0] o_sin;
  logic [BITS-1:0] o_theta;

  // Preprocessor side: takes angles, produces seeded stage-0 operands.
  modport slave (
    input  i_valid, i_theta,
    output o_ready, o_valid, o_sign, o_cos, o_sin, o_theta
  );

  // Environment side: supplies angles, observes stage-0 operands.
  modport master (
    output i_valid, i_theta,
    input  o_ready, o_valid, o_sign, o_cos, o_sin, o_theta
  );
endinterface

// File: rtl/cordic_sincos_preproc.sv
// CORDIC sin/cos input stage: folds [-pi, pi) into [-pi/2, pi/2], seeds
// cos/sin, and holds one angle in a skid register across pipeline stalls.
module cordic_sincos_preproc #(
  parameter int BITS   = 16,
  parameter int K_INIT = 9949
) (
  input logic                    i_clk,
  input logic                    i_rst,
  input logic                    i_pipeline_en,
  cordic_sincos_preproc_if.slave bus
);

  logic            fold_sign;
  logic [BITS-1:0] fold_theta;
  logic            accept;

  logic            skid_full;
  logic            skid_sign;
  logic [BITS-1:0] skid_theta;

  logic            out_valid;
  logic            out_sign;
  logic [BITS-1:0] out_cos;
  logic [BITS-1:0] out_sin;
  logic [BITS-1:0] out_theta;

  // Fold: angles in the outer half-circle are rotated by pi (MSB flip).
  always_comb begin
    fold_sign  = bus.i_theta[BITS-1] ^ bus.i_theta[BITS-2];
    fold_theta = bus.i_theta;
    fold_theta[BITS-1] = bus.i_theta[BITS-1] ^ fold_sign;
  end

  assign accept = bus.i_valid & ~skid_full;

  // Output stage and skid register; a full skid always drains first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      skid_full  <= 1'b0;
      skid_sign  <= 1'b0;
      skid_theta <= '0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_cos    <= '0;
      out_sin    <= '0;
      out_theta  <= '0;
    end else if (i_pipeline_en) begin
      if (skid_full) begin
        out_valid <= 1'b1;
        out_sign  <= skid_sign;
        out_theta <= skid_theta;
        out_cos   <= BITS'(K_INIT);
        out_sin   <= '0;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_sign  <= fold_sign;
        out_theta <= fold_theta;
        out_cos   <= BITS'(K_INIT);
        out_sin   <= '0;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_full  <= 1'b1;
      skid_sign  <= fold_sign;
      skid_theta <= fold_theta;
    end
  end

  assign bus.o_ready = ~skid_full;
  assign bus.o_valid = out_valid;
  assign bus.o_sign  = out_sign;
  assign bus.o_cos   = out_cos;
  assign bus.o_sin   = out_sin;
  assign bus.o_theta = out_theta;

endmodule

// File: tb/tb_cordic_sincos_preproc.sv
// Directed and randomized checks for the CORDIC sin/cos input stage.
module tb_cordic_sincos_preproc;

  localparam int BITS   = 16;
  localparam int K_INIT = 9949;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_pipeline_en;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cordic_sincos_preproc_if #(.BITS(BITS)) bus ();

  cordic_sincos_preproc #(.BITS(BITS), .K_INIT(K_INIT)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pipeline_en (i_pipeline_en),
    .bus           (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference fold written from the angle ranges rather than the bit trick.
  function automatic logic [16:0] ref_fold(input logic [15:0] th);
    int s;
    logic sg;
    s  = int'($signed(th));
    sg = (s >= 16384) || (s < -16384);
    return {sg, sg ? 16'(th + 16'h8000) : th};
  endfunction

  task automatic check_out(input string tag, input logic sg, input logic [15:0] th);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, ".sign"},  32'(bus.o_sign), 32'(sg));
    check({tag, ".theta"}, 32'(bus.o_theta), 32'(th));
    check({tag, ".cos"},   32'(bus.o_cos), 32'(K_INIT));
    check({tag, ".sin"},   32'(bus.o_sin), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, ".sign"},  32'(bus.o_sign), 32'd0);
    check({tag, ".theta"}, 32'(bus.o_theta), 32'd0);
    check({tag, ".cos"},   32'(bus.o_cos), 32'd0);
    check({tag, ".sin"},   32'(bus.o_sin), 32'd0);
    check({tag, ".ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  logic [15:0] fold_in  [5] = '{16'h6000, 16'hA000, 16'h8000, 16'h4000, 16'hC000};
  logic        fold_sg  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] fold_th  [5] = '{16'hE000, 16'h2000, 16'h0000, 16'hC000, 16'hC000};

  initial begin
    logic [16:0] sb[$];
    logic [16:0] exp_s;
    logic acc, en_pre, rdy_pre;

    i_rst = 1'b1; i_pipeline_en = 1'b0;
    bus.i_valid = 1'b0; bus.i_theta = '0;
    tick(); tick();
    check_zero("reset");
    i_rst = 1'b0;
    tick();
    check("post_reset.ready", 32'(bus.o_ready), 32'd1);
    check("post_reset.valid", 32'(bus.o_valid), 32'd0);

    // First sample, pi/4
    i_pipeline_en = 1'b1; bus.i_valid = 1'b1; bus.i_theta = 16'h2000;
    tick();
    check_out("first", 1'b0, 16'h2000);

    // Fold boundary cases back-to-back
    for (int i = 0; i < 5; i++) begin
      bus.i_theta = fold_in[i];
      check($sformatf("fold%0d.ready", i), 32'(bus.o_ready), 32'd1);
      tick();
      check_out($sformatf("fold%0d", i), fold_sg[i], fold_th[i]);
    end

    // Stall with absorb, then drain
    bus.i_theta = 16'h1000;
    tick();
    check_out("stall.pre", 1'b0, 16'h1000);
    i_pipeline_en = 1'b0; bus.i_theta = 16'h7000;
    tick();
    check("stall.ready", 32'(bus.o_ready), 32'd0);
    check_out("stall.hold", 1'b0, 16'h1000);
    i_pipeline_en = 1'b1; bus.i_theta = 16'h0100;
    tick();
    check_out("drain", 1'b1, 16'hF000);
    check("drain.ready", 32'(bus.o_ready), 32'd1);
    tick();
    check_out("after_drain", 1'b0, 16'h0100);

    // Idle bubble with enable high
    bus.i_valid = 1'b0; bus.i_theta = 16'h5555;
    tick();
    check("bubble.valid", 32'(bus.o_valid), 32'd0);
    check("bubble.theta", 32'(bus.o_theta), 32'h0100);

    // Valid output held while enable is low
    bus.i_valid = 1'b1; bus.i_theta = 16'h3000;
    tick();
    i_pipeline_en = 1'b0; bus.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_out("hold", 1'b0, 16'h3000);

    // Reset with skid full discards everything
    bus.i_valid = 1'b1; bus.i_theta = 16'h5000;
    tick();
    check("prerst.ready", 32'(bus.o_ready), 32'd0);
    check("prerst.valid", 32'(bus.o_valid), 32'd1);
    i_rst = 1'b1; i_pipeline_en = 1'b1;
    tick();
    check_zero("midrst");
    i_rst = 1'b0; bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst.gone%0d", i), 32'(bus.o_valid), 32'd0);
    end

    // Random traffic against a scoreboard
    for (int c = 0; c < 10000; c++) begin
      i_pipeline_en = ($urandom_range(0, 3) != 0);
      bus.i_valid   = $urandom_range(0, 1) == 1;
      bus.i_theta   = 16'($urandom);
      acc     = bus.i_valid & bus.o_ready;
      en_pre  = i_pipeline_en;
      rdy_pre = bus.o_ready;
      if (acc) sb.push_back(ref_fold(bus.i_theta));
      tick();
      if (en_pre && !rdy_pre) check("rnd.ready_recover", 32'(bus.o_ready), 32'd1);
      if (en_pre && bus.o_valid) begin
        if (sb.size() == 0) begin
          check("rnd.spurious", 32'd1, 32'd0);
        end else begin
          exp_s = sb.pop_front();
          check("rnd.sample", 32'({bus.o_sign, bus.o_theta}), 32'(exp_s));
          check("rnd.cos", 32'(bus.o_cos), 32'(K_INIT));
        end
      end
    end
    i_pipeline_en = 1'b1; bus.i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          check("rnd.spurious", 32'd1, 32'd0);
        end else begin
          exp_s = sb.pop_front();
          check("rnd.tail", 32'({bus.o_sign, bus.o_theta}), 32'(exp_s));
        end
      end
    end
    check("rnd.lost", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
